// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle LEGv8 main control FSM:
// opcode patterns, ALUop encodings, state encodings and the per-state
// Moore control bundle.
package multicycle_control_pkg;

    // Fully specified opcodes
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // Prefix-matched opcodes (the low bits belong to the immediate/offset)
    localparam logic [9:0]  OP_ORRI_PFX = 10'b1011001000;
    localparam logic [7:0]  OP_CBZ_PFX  = 8'b10110100;
    localparam logic [5:0]  OP_B_PFX    = 6'b000101;

    // ALUop encodings seen by the ALU control stage
    localparam logic [1:0]  ALUOP_ADD   = 2'b00;
    localparam logic [1:0]  ALUOP_CBZ   = 2'b01;
    localparam logic [1:0]  ALUOP_RTYPE = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_MEM = 4'd7,
        S_CBZ    = 4'd8,
        S_BR     = 4'd9
    } state_t;

    // One-hot instruction class; ORRI is kept apart from R so the FSM can
    // select the immediate operand without looking at the raw opcode.
    typedef struct packed {
        logic r;
        logic orri;
        logic ldur;
        logic stur;
        logic cbz;
        logic b;
        logic ill;
    } op_class_t;

    // Control outputs that depend only on the state (and on the class
    // latched at the DECODE edge). Handshake-gated outputs are not here.
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg2loc;
        logic       mem_req;
        logic       mem_write;
        logic       pc_src;
        logic       pc_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t st, input logic is_orri,
                                         input logic is_stur);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_req = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_op  = ALUOP_RTYPE;
                c.alu_src = is_orri;
            end
            S_WB_R: begin
                c.alu_op    = ALUOP_RTYPE;
                c.reg_write = 1'b1;
            end
            S_ADDR: begin
                c.alu_src = 1'b1;
                c.reg2loc = is_stur;
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.alu_src = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.reg2loc   = 1'b1;
            end
            S_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_CBZ: begin
                c.alu_op  = ALUOP_CBZ;
                c.reg2loc = 1'b1;
                c.pc_src  = 1'b1;
            end
            S_BR: begin
                c.pc_src   = 1'b1;
                c.pc_write = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_opcode_class_decode.sv
// Combinational opcode classifier: maps the 11-bit opcode field to a
// one-hot instruction class. Anything unrecognised is flagged illegal.
module opcode_class_decode
    import multicycle_control_pkg::*;
(
    input  logic [10:0] i_opcode,
    output op_class_t   o_class
);

    // Priority chain is safe: the legal patterns do not overlap.
    always_comb begin
        o_class = '0;
        if ((i_opcode == OP_ADD) || (i_opcode == OP_SUB) ||
            (i_opcode == OP_AND) || (i_opcode == OP_ORR)) begin
            o_class.r = 1'b1;
        end else if (i_opcode[10:1] == OP_ORRI_PFX) begin
            o_class.orri = 1'b1;
        end else if (i_opcode == OP_LDUR) begin
            o_class.ldur = 1'b1;
        end else if (i_opcode == OP_STUR) begin
            o_class.stur = 1'b1;
        end else if (i_opcode[10:3] == OP_CBZ_PFX) begin
            o_class.cbz = 1'b1;
        end else if (i_opcode[10:5] == OP_B_PFX) begin
            o_class.b = 1'b1;
        end else begin
            o_class.ill = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle LEGv8 datapath. Sequences each
// instruction through fetch/decode/execute/memory/write-back, drives ALUop
// and datapath enables, handshakes with a variable-latency memory and
// counts retired instructions.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [10:0]       Opcode,
    input  logic              Zero,
    input  logic              MemReady,
    output logic [1:0]        ALUop,
    output logic              ALUSrc,
    output logic              Reg2Loc,
    output logic              MemReq,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemtoReg,
    output logic              Illegal,
    output logic [ADDR_W-1:0] Retired
);

    state_t              r_state;
    ctrl_t               r_ctrl;
    logic [ADDR_W-1:0]   r_retired;
    op_class_t           w_cls;
    logic                w_live;
    logic                w_in_fetch;
    logic                w_in_cbz;

    opcode_class_decode u_decode (
        .i_opcode (Opcode),
        .o_class  (w_cls)
    );

    // State register, registered Moore controls for the state being
    // entered, and the retired-instruction counter.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= S_FETCH;
            r_ctrl    <= state_ctrl(S_FETCH, 1'b0, 1'b0);
            r_retired <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (MemReady) begin
                        r_state <= S_DECODE;
                        r_ctrl  <= state_ctrl(S_DECODE, 1'b0, 1'b0);
                    end
                end
                S_DECODE: begin
                    if (w_cls.r || w_cls.orri) begin
                        r_state <= S_EXEC_R;
                        r_ctrl  <= state_ctrl(S_EXEC_R, w_cls.orri, 1'b0);
                    end else if (w_cls.ldur || w_cls.stur) begin
                        r_state <= S_ADDR;
                        r_ctrl  <= state_ctrl(S_ADDR, 1'b0, w_cls.stur);
                    end else if (w_cls.cbz) begin
                        r_state <= S_CBZ;
                        r_ctrl  <= state_ctrl(S_CBZ, 1'b0, 1'b0);
                    end else if (w_cls.b) begin
                        r_state <= S_BR;
                        r_ctrl  <= state_ctrl(S_BR, 1'b0, 1'b0);
                    end else begin
                        // Illegal: PC+4 already taken in FETCH, nothing retires
                        r_state <= S_FETCH;
                        r_ctrl  <= state_ctrl(S_FETCH, 1'b0, 1'b0);
                    end
                end
                S_EXEC_R: begin
                    r_state <= S_WB_R;
                    r_ctrl  <= state_ctrl(S_WB_R, 1'b0, 1'b0);
                end
                S_ADDR: begin
                    if (w_cls.stur) begin
                        r_state <= S_MEM_WR;
                        r_ctrl  <= state_ctrl(S_MEM_WR, 1'b0, 1'b1);
                    end else begin
                        r_state <= S_MEM_RD;
                        r_ctrl  <= state_ctrl(S_MEM_RD, 1'b0, 1'b0);
                    end
                end
                S_MEM_RD: begin
                    if (MemReady) begin
                        r_state <= S_WB_MEM;
                        r_ctrl  <= state_ctrl(S_WB_MEM, 1'b0, 1'b0);
                    end
                end
                S_MEM_WR: begin
                    if (MemReady) begin
                        r_state   <= S_FETCH;
                        r_ctrl    <= state_ctrl(S_FETCH, 1'b0, 1'b0);
                        r_retired <= r_retired + ADDR_W'(1);
                    end
                end
                S_WB_R, S_WB_MEM, S_CBZ, S_BR: begin
                    r_state   <= S_FETCH;
                    r_ctrl    <= state_ctrl(S_FETCH, 1'b0, 1'b0);
                    r_retired <= r_retired + ADDR_W'(1);
                end
                default: begin
                    r_state <= S_FETCH;
                    r_ctrl  <= state_ctrl(S_FETCH, 1'b0, 1'b0);
                end
            endcase
        end
    end

    // Reset forces every output low, including the handshake-gated ones,
    // even in the first reset cycle while the old state is still held.
    assign w_live     = !Reset;
    assign w_in_fetch = (r_state == S_FETCH);
    assign w_in_cbz   = (r_state == S_CBZ);

    assign ALUop    = w_live ? r_ctrl.alu_op : 2'b00;
    assign ALUSrc   = w_live & r_ctrl.alu_src;
    assign Reg2Loc  = w_live & r_ctrl.reg2loc;
    assign MemReq   = w_live & r_ctrl.mem_req;
    assign MemWrite = w_live & r_ctrl.mem_write;
    assign PCSrc    = w_live & r_ctrl.pc_src;
    assign RegWrite = w_live & r_ctrl.reg_write;
    assign MemtoReg = w_live & r_ctrl.mem_to_reg;
    assign Retired  = w_live ? r_retired : '0;

    // Same-cycle exceptions: fetch completion, CBZ outcome, illegal flag
    assign IRWrite  = w_live & w_in_fetch & MemReady;
    assign PCWrite  = w_live & (r_ctrl.pc_write | (w_in_fetch & MemReady) |
                                (w_in_cbz & Zero));
    assign Illegal  = w_live & (r_state == S_DECODE) & w_cls.ill;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios followed by randomized
// instruction streams, checked cycle by cycle against an expected trace
// built from each instruction class's step list.
module tb_multicycle_control;

    localparam int AW = 4;

    localparam int C_R = 0, C_ORRI = 1, C_LDUR = 2, C_STUR = 3,
                   C_CBZ = 4, C_B = 5, C_ILL = 6;

    // Observed vector: {ALUop, ALUSrc, Reg2Loc, MemReq, MemWrite, IRWrite,
    //                   PCWrite, PCSrc, RegWrite, MemtoReg, Illegal}
    localparam logic [11:0] AOP_R = 12'b1000_0000_0000;
    localparam logic [11:0] AOP_C = 12'b0100_0000_0000;
    localparam logic [11:0] ASRC  = 12'b0010_0000_0000;
    localparam logic [11:0] R2L   = 12'b0001_0000_0000;
    localparam logic [11:0] MREQ  = 12'b0000_1000_0000;
    localparam logic [11:0] MWR   = 12'b0000_0100_0000;
    localparam logic [11:0] IRW   = 12'b0000_0010_0000;
    localparam logic [11:0] PCW   = 12'b0000_0001_0000;
    localparam logic [11:0] PCS   = 12'b0000_0000_1000;
    localparam logic [11:0] RGW   = 12'b0000_0000_0100;
    localparam logic [11:0] M2R   = 12'b0000_0000_0010;
    localparam logic [11:0] ILL   = 12'b0000_0000_0001;

    typedef struct packed {
        logic [10:0] op;
        logic        mr;
        logic        z;
        logic        ret;
        logic [11:0] out;
    } cyc_t;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [10:0]   Opcode;
    logic          Zero;
    logic          MemReady;
    logic [1:0]    ALUop;
    logic          ALUSrc, Reg2Loc, MemReq, MemWrite, IRWrite, PCWrite;
    logic          PCSrc, RegWrite, MemtoReg, Illegal;
    logic [AW-1:0] Retired;
    logic [11:0]   w_obs;

    cyc_t          q[$];
    logic [AW-1:0] exp_ret;
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;

    always #5 CLK = ~CLK;

    multicycle_control #(.ADDR_W(AW)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Opcode   (Opcode),
        .Zero     (Zero),
        .MemReady (MemReady),
        .ALUop    (ALUop),
        .ALUSrc   (ALUSrc),
        .Reg2Loc  (Reg2Loc),
        .MemReq   (MemReq),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemtoReg (MemtoReg),
        .Illegal  (Illegal),
        .Retired  (Retired)
    );

    assign w_obs = {ALUop, ALUSrc, Reg2Loc, MemReq, MemWrite, IRWrite,
                    PCWrite, PCSrc, RegWrite, MemtoReg, Illegal};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction class straight from the opcode table (wildcard matching)
    function automatic int classify(input logic [10:0] op);
        if (op ==? 11'b10001011000 || op ==? 11'b11001011000 ||
            op ==? 11'b10001010000 || op ==? 11'b10101010000) return C_R;
        if (op ==? 11'b1011001000x) return C_ORRI;
        if (op ==? 11'b11111000010) return C_LDUR;
        if (op ==? 11'b11111000000) return C_STUR;
        if (op ==? 11'b10110100xxx) return C_CBZ;
        if (op ==? 11'b000101xxxxx) return C_B;
        return C_ILL;
    endfunction

    function automatic logic [10:0] pick_op(input int cls);
        logic [10:0] op;
        case (cls)
            C_R: begin
                case ($urandom_range(0, 3))
                    0:       op = 11'b10001011000;
                    1:       op = 11'b11001011000;
                    2:       op = 11'b10001010000;
                    default: op = 11'b10101010000;
                endcase
            end
            C_ORRI: op = {10'b1011001000, rb()};
            C_LDUR: op = 11'b11111000010;
            C_STUR: op = 11'b11111000000;
            C_CBZ:  op = {8'b10110100, 3'($urandom_range(0, 7))};
            C_B:    op = {6'b000101, 5'($urandom_range(0, 31))};
            default: begin
                op = 11'($urandom);
                while (classify(op) != C_ILL) op = 11'($urandom);
            end
        endcase
        return op;
    endfunction

    task automatic push(input logic [10:0] op, input logic mr, input logic z,
                        input logic ret, input logic [11:0] o);
        cyc_t c;
        c.op = op; c.mr = mr; c.z = z; c.ret = ret; c.out = o;
        q.push_back(c);
    endtask

    // Expected per-cycle trace of one instruction: fw fetch waits, mw
    // memory waits, z is the Zero flag seen by CBZ.
    task automatic gen_instr(input int cls, input logic [10:0] op, input int fw,
                             input int mw, input logic z);
        for (int i = 0; i < fw; i++) push(op, 1'b0, rb(), 1'b0, MREQ);
        push(op, 1'b1, rb(), 1'b0, MREQ | IRW | PCW);
        push(op, rb(), rb(), 1'b0, (cls == C_ILL) ? ILL : 12'h000);
        case (cls)
            C_R, C_ORRI: begin
                push(op, rb(), rb(), 1'b0, AOP_R | ((cls == C_ORRI) ? ASRC : 12'h000));
                push(op, rb(), rb(), 1'b1, AOP_R | RGW);
            end
            C_LDUR: begin
                push(op, rb(), rb(), 1'b0, ASRC);
                for (int i = 0; i < mw; i++) push(op, 1'b0, rb(), 1'b0, MREQ | ASRC);
                push(op, 1'b1, rb(), 1'b0, MREQ | ASRC);
                push(op, rb(), rb(), 1'b1, RGW | M2R);
            end
            C_STUR: begin
                push(op, rb(), rb(), 1'b0, ASRC | R2L);
                for (int i = 0; i < mw; i++)
                    push(op, 1'b0, rb(), 1'b0, MREQ | MWR | ASRC | R2L);
                push(op, 1'b1, rb(), 1'b1, MREQ | MWR | ASRC | R2L);
            end
            C_CBZ: push(op, rb(), z, 1'b1, AOP_C | R2L | PCS | (z ? PCW : 12'h000));
            C_B:   push(op, rb(), rb(), 1'b1, PCS | PCW);
            default: ;
        endcase
    endtask

    // Drive each queued cycle just after the rising edge, check mid-cycle
    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            Opcode   = c.op;
            MemReady = c.mr;
            Zero     = c.z;
            @(negedge CLK);
            chk($sformatf("ctl@%0d", cyc), 64'(w_obs), 64'(c.out));
            chk($sformatf("retired@%0d", cyc), 64'(Retired), 64'(exp_ret));
            @(posedge CLK);
            #1;
            if (c.ret) exp_ret = exp_ret + 1'b1;
            cyc++;
        end
    endtask

    initial begin
        int cls;
        logic [10:0] op;

        Reset = 1'b1; Opcode = '0; MemReady = 1'b0; Zero = 1'b0; exp_ret = '0;
        @(posedge CLK); #1;
        MemReady = 1'b1; Zero = 1'b1;
        @(negedge CLK);
        chk("reset_outs", 64'(w_obs), 64'd0);
        chk("reset_retired", 64'(Retired), 64'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;

        // ADD, all ready
        gen_instr(C_R, 11'b10001011000, 0, 0, 1'b0);
        run_q();
        chk("add_retired", 64'(Retired), 64'd1);
        // LDUR with three memory-wait cycles (eight cycles total)
        gen_instr(C_LDUR, 11'b11111000010, 0, 3, 1'b0);
        // CBZ taken then not taken
        gen_instr(C_CBZ, 11'b10110100101, 0, 0, 1'b1);
        gen_instr(C_CBZ, 11'b10110100010, 0, 0, 1'b0);
        // Illegal all-zero opcode
        gen_instr(C_ILL, 11'b00000000000, 0, 0, 1'b0);
        // ORRI uses the immediate operand
        gen_instr(C_ORRI, 11'b10110010001, 0, 0, 1'b0);
        run_q();

        // Randomized instruction stream (counter wraps several times)
        for (int k = 0; k < 60; k++) begin
            cls = $urandom_range(0, 6);
            op  = pick_op(cls);
            gen_instr(cls, op, $urandom_range(0, 3), $urandom_range(0, 3), rb());
            run_q();
        end

        // STUR interrupted by reset while waiting in MEM_WR
        op = 11'b11111000000;
        push(op, 1'b1, rb(), 1'b0, MREQ | IRW | PCW);
        push(op, rb(), rb(), 1'b0, 12'h000);
        push(op, rb(), rb(), 1'b0, ASRC | R2L);
        push(op, 1'b0, rb(), 1'b0, MREQ | MWR | ASRC | R2L);
        push(op, 1'b0, rb(), 1'b0, MREQ | MWR | ASRC | R2L);
        run_q();
        Reset = 1'b1; MemReady = 1'b1; Zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk($sformatf("midreset_outs%0d", i), 64'(w_obs), 64'd0);
            chk($sformatf("midreset_retired%0d", i), 64'(Retired), 64'd0);
            @(posedge CLK); #1;
        end
        Reset = 1'b0;
        exp_ret = '0;
        gen_instr(C_STUR, op, 1, 1, 1'b0);
        gen_instr(C_B, 11'b00010100011, 0, 0, 1'b0);
        run_q();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
